// File: rtl/cv32e40x_fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, buffers returned words and
// discards responses belonging to a flushed stream. Optional perf counter: FETCH_QUEUE_PERF_EN.

module cv32e40x_fetch_queue_chk #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             resp_valid,
    input logic [CNT_W-1:0] count,
    input logic [CNT_W-1:0] outstanding
);
    resp_into_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(resp_valid && (count == CNT_W'(DEPTH))));

    occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, count} + {1'b0, outstanding}) <= (CNT_W+1)'(DEPTH)));
endmodule

module cv32e40x_fetch_queue #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        kill_i,
    output logic        trans_valid_o,
    input  logic        trans_ready_i,
    output logic [31:0] trans_addr_o,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        busy_o
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic        perf_starve_o
`endif
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]       q_rdata_r [DEPTH];
    logic [31:0]       q_addr_r  [DEPTH];
    logic [DEPTH-1:0]  q_err_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic [31:0]       af_addr_r [MAX_OUTSTANDING];
    logic [AW-1:0]     af_rd_r;
    logic [AW-1:0]     af_wr_r;

    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  discard_r;
    logic [31:0]       fetch_addr_r;
    logic              stopped_r;

    logic              flush_s;
    logic [31:0]       target_s;
    logic              credit_ok_s;
    logic              accept_s;
    logic              pop_s;
    logic              keep_s;
    logic              unused_addr_bits_s;

    function automatic logic [PW-1:0] q_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    function automatic logic [AW-1:0] af_next(input logic [AW-1:0] p);
        if (p == AW'(MAX_OUTSTANDING - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign flush_s            = branch_i | kill_i;
    assign target_s           = {branch_addr_i[31:2], 2'b00};
    assign unused_addr_bits_s = ^branch_addr_i[1:0];

    // While branching the queue is being emptied, so only in-flight requests consume credit.
    always_comb begin
        credit_ok_s = 1'b0;
        if (branch_i) begin
            credit_ok_s = (outstanding_r < CNT_W'(DEPTH));
        end else begin
            credit_ok_s = (({1'b0, count_r} + {1'b0, outstanding_r}) < (CNT_W+1)'(DEPTH));
        end
    end

    assign trans_valid_o = fetch_en_i && !kill_i && (!stopped_r || branch_i) &&
                           (outstanding_r < CNT_W'(MAX_OUTSTANDING)) && credit_ok_s;
    assign trans_addr_o  = branch_i ? target_s : fetch_addr_r;
    assign accept_s      = trans_valid_o && trans_ready_i;

    assign out_valid_o = (count_r != {CNT_W{1'b0}});
    assign out_rdata_o = q_rdata_r[rd_ptr_r];
    assign out_addr_o  = q_addr_r[rd_ptr_r];
    assign out_err_o   = q_err_r[rd_ptr_r];
    assign busy_o      = (outstanding_r != {CNT_W{1'b0}}) || (discard_r != {CNT_W{1'b0}});

    assign pop_s  = out_valid_o && out_ready_i && !flush_s;
    assign keep_s = resp_valid_i && (discard_r == {CNT_W{1'b0}}) && !flush_s;

    // Word queue: storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_rdata_r[i] <= 32'h0000_0000;
                q_addr_r[i]  <= 32'h0000_0000;
            end
            q_err_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (keep_s) begin
                q_rdata_r[wr_ptr_r] <= resp_rdata_i;
                q_addr_r[wr_ptr_r]  <= af_addr_r[af_rd_r];
                q_err_r[wr_ptr_r]   <= resp_err_i;
            end
            if (flush_s) begin
                rd_ptr_r <= {PW{1'b0}};
                wr_ptr_r <= {PW{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (keep_s) begin
                    wr_ptr_r <= q_next(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= q_next(rd_ptr_r);
                end
                case ({keep_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Request address FIFO; only live-stream requests are tracked, so dropped responses never pop it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                af_addr_r[i] <= 32'h0000_0000;
            end
            af_rd_r <= {AW{1'b0}};
            af_wr_r <= {AW{1'b0}};
        end else if (flush_s) begin
            af_rd_r <= {AW{1'b0}};
            if (accept_s) begin
                af_addr_r[0] <= trans_addr_o;
                af_wr_r      <= af_next({AW{1'b0}});
            end else begin
                af_wr_r <= {AW{1'b0}};
            end
        end else begin
            if (accept_s) begin
                af_addr_r[af_wr_r] <= trans_addr_o;
                af_wr_r            <= af_next(af_wr_r);
            end
            if (keep_s) begin
                af_rd_r <= af_next(af_rd_r);
            end
        end
    end

    // Bus bookkeeping, stale-response discard and fetch address sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
            fetch_addr_r  <= 32'h0000_0000;
            stopped_r     <= 1'b1;
        end else begin
            case ({accept_s, resp_valid_i})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (flush_s) begin
                discard_r <= outstanding_r - {{(CNT_W-1){1'b0}}, resp_valid_i};
            end else if (resp_valid_i && (discard_r != {CNT_W{1'b0}})) begin
                discard_r <= discard_r - CNT_W'(1);
            end else begin
                discard_r <= discard_r;
            end
            if (accept_s) begin
                fetch_addr_r <= trans_addr_o + 32'd4;
            end else if (branch_i) begin
                fetch_addr_r <= target_s;
            end else begin
                fetch_addr_r <= fetch_addr_r;
            end
            if (kill_i) begin
                stopped_r <= 1'b1;
            end else if (branch_i) begin
                stopped_r <= 1'b0;
            end else begin
                stopped_r <= stopped_r;
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] starve_cnt_q;

    assign perf_starve_o = out_ready_i && !out_valid_o && !branch_i;

    // Saturating count of cycles the consumer waited on an empty queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 32'h0000_0000;
        end else if (perf_starve_o && (starve_cnt_q != 32'hFFFF_FFFF)) begin
            starve_cnt_q <= starve_cnt_q + 32'd1;
        end else begin
            starve_cnt_q <= starve_cnt_q;
        end
    end
`endif

    cv32e40x_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .resp_valid  (resp_valid_i),
        .count       (count_r),
        .outstanding (outstanding_r)
    );
endmodule

// File: tb/tb_cv32e40x_fetch_queue.sv
// Bench for cv32e40x_fetch_queue: directed scenarios plus randomized traffic against a
// queue-based reference model (DEPTH=2) and an in-order stream scoreboard (DEPTH=3).
module tb_cv32e40x_fetch_queue;
    localparam int DA = 2, MA = 2, DB = 3, MB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_fetch_en, a_branch, a_kill, a_tready, a_rvalid, a_rerr, a_ordy;
    logic [31:0] a_baddr, a_rdata;
    logic        a_tvalid, a_ovalid, a_oerr, a_busy;
    logic [31:0] a_taddr, a_ordata, a_oaddr;

    logic        b_fetch_en, b_branch, b_kill, b_tready, b_rvalid, b_rerr, b_ordy;
    logic [31:0] b_baddr, b_rdata;
    logic        b_tvalid, b_ovalid, b_oerr, b_busy;
    logic [31:0] b_taddr, b_ordata, b_oaddr;

    cv32e40x_fetch_queue #(.DEPTH(DA), .MAX_OUTSTANDING(MA)) dut_a (
        .clk(clk), .rst_n(rst_n), .fetch_en_i(a_fetch_en), .branch_i(a_branch),
        .branch_addr_i(a_baddr), .kill_i(a_kill), .trans_valid_o(a_tvalid),
        .trans_ready_i(a_tready), .trans_addr_o(a_taddr), .resp_valid_i(a_rvalid),
        .resp_rdata_i(a_rdata), .resp_err_i(a_rerr), .out_valid_o(a_ovalid),
        .out_ready_i(a_ordy), .out_rdata_o(a_ordata), .out_addr_o(a_oaddr),
        .out_err_o(a_oerr), .busy_o(a_busy));

    cv32e40x_fetch_queue #(.DEPTH(DB), .MAX_OUTSTANDING(MB)) dut_b (
        .clk(clk), .rst_n(rst_n), .fetch_en_i(b_fetch_en), .branch_i(b_branch),
        .branch_addr_i(b_baddr), .kill_i(b_kill), .trans_valid_o(b_tvalid),
        .trans_ready_i(b_tready), .trans_addr_o(b_taddr), .resp_valid_i(b_rvalid),
        .resp_rdata_i(b_rdata), .resp_err_i(b_rerr), .out_valid_o(b_ovalid),
        .out_ready_i(b_ordy), .out_rdata_o(b_ordata), .out_addr_o(b_oaddr),
        .out_err_o(b_oerr), .busy_o(b_busy));

    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic err; } word_t;
    typedef struct packed { logic [31:0] addr; logic stale; } req_t;

    // Reference model: buffered words, requests on the bus, next sequential address, stop flag.
    word_t       mq[$];
    req_t        fl[$];
    logic [31:0] m_faddr;
    bit          m_stopped;

    int n_checks = 0;
    int n_pass   = 0;
    int dut_inflight, max_inflight;

    logic        exp_tv, exp_ov, exp_busy, obs_tv, obs_ov, obs_busy;
    logic [31:0] exp_ta, obs_ta;
    word_t       exp_head, obs_head;
    bit          cyc_flush, cyc_acc, cyc_pop;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic err_of(input logic [31:0] a);
        return (a[5:2] == 4'hF);
    endfunction

    task automatic idle_inputs();
        a_fetch_en = 1'b0; a_branch = 1'b0; a_baddr = 32'h0; a_kill = 1'b0;
        a_tready = 1'b0; a_rvalid = 1'b0; a_rdata = 32'h0; a_rerr = 1'b0; a_ordy = 1'b0;
        b_fetch_en = 1'b0; b_branch = 1'b0; b_baddr = 32'h0; b_kill = 1'b0;
        b_tready = 1'b0; b_rvalid = 1'b0; b_rdata = 32'h0; b_rerr = 1'b0; b_ordy = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete(); fl.delete();
        m_faddr = 32'h0; m_stopped = 1'b1;
        dut_inflight = 0; max_inflight = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of dut_a: drive inputs, record model expectations and DUT outputs, advance model.
    task automatic step_a(input bit fe, input bit br, input logic [31:0] ba, input bit kl,
                          input bit tr, input bit rv, input bit ordy);
        req_t e; word_t w; logic [31:0] tgt; int n_in, n_q; bit cred, acc, pop, rsp;
        @(posedge clk); #1;
        rsp = rv && (fl.size() > 0);
        a_fetch_en = fe; a_branch = br; a_baddr = ba; a_kill = kl; a_tready = tr; a_ordy = ordy;
        a_rvalid = rsp;
        a_rdata  = rsp ? mem_data(fl[0].addr) : $urandom;
        a_rerr   = rsp ? err_of(fl[0].addr) : 1'b0;
        #2;
        cyc_flush = br || kl;
        tgt  = {ba[31:2], 2'b00};
        n_in = fl.size(); n_q = mq.size();
        cred = br ? (n_in < DA) : ((n_q + n_in) < DA);
        exp_tv   = fe && !kl && (!m_stopped || br) && (n_in < MA) && cred;
        exp_ta   = br ? tgt : m_faddr;
        exp_ov   = (n_q > 0);
        exp_head = (n_q > 0) ? mq[0] : '0;
        exp_busy = (n_in > 0);
        obs_tv = a_tvalid; obs_ta = a_taddr; obs_ov = a_ovalid; obs_busy = a_busy;
        obs_head.addr = a_oaddr; obs_head.data = a_ordata; obs_head.err = a_oerr;
        cyc_acc = a_tvalid && tr;
        cyc_pop = a_ovalid && ordy && !cyc_flush;
        dut_inflight = dut_inflight + (cyc_acc ? 1 : 0) - (rsp ? 1 : 0);
        if (dut_inflight > max_inflight) max_inflight = dut_inflight;
        acc = exp_tv && tr;
        pop = exp_ov && ordy && !cyc_flush;
        if (pop) w = mq.pop_front();
        if (rsp) begin
            e = fl.pop_front();
            if (!e.stale && !cyc_flush) begin
                w.addr = e.addr; w.data = mem_data(e.addr); w.err = err_of(e.addr);
                mq.push_back(w);
            end
        end
        if (cyc_flush) begin
            mq.delete();
            foreach (fl[i]) fl[i].stale = 1'b1;
        end
        if (acc) begin
            e.addr = exp_ta; e.stale = 1'b0;
            fl.push_back(e);
        end
        m_faddr = acc ? (exp_ta + 32'd4) : (br ? tgt : m_faddr);
        if (kl) m_stopped = 1'b1;
        else if (br) m_stopped = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        a_fetch_en = 1'b1; a_ordy = 1'b1;
        #2;
        n_checks++; if (a_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", a_tvalid); else n_pass++;
        n_checks++; if (a_ovalid !== 1'b0) $display("FAIL reset_ovalid got %b want 0", a_ovalid); else n_pass++;
        n_checks++; if (a_ordata !== 32'h0) $display("FAIL reset_rdata got %h want 0", a_ordata); else n_pass++;
        n_checks++; if (a_oaddr !== 32'h0) $display("FAIL reset_addr got %h want 0", a_oaddr); else n_pass++;
        n_checks++; if (a_oerr !== 1'b0) $display("FAIL reset_err got %b want 0", a_oerr); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (obs_tv !== 1'b0) $display("FAIL post_reset_tvalid got %b want 0", obs_tv); else n_pass++;
        n_checks++; if (obs_ov !== 1'b0) $display("FAIL post_reset_ovalid got %b want 0", obs_ov); else n_pass++;
    endtask

    task automatic test_linear();
        logic [31:0] got_a[$]; logic [31:0] got_d[$];
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step_a(1'b1, (i == 0), 32'h100, 1'b0, 1'b1, 1'b1, 1'b1);
            n_checks++; if (obs_tv !== exp_tv) $display("FAIL linear_tvalid cyc %0d got %b want %b", i, obs_tv, exp_tv); else n_pass++;
            n_checks++; if (obs_ov !== exp_ov) $display("FAIL linear_ovalid cyc %0d got %b want %b", i, obs_ov, exp_ov); else n_pass++;
            if (cyc_pop) begin got_a.push_back(obs_head.addr); got_d.push_back(obs_head.data); end
        end
        n_checks++; if (got_a.size() < 3) $display("FAIL linear_count got %0d want >=3", got_a.size()); else n_pass++;
        for (int k = 0; k < 3 && k < got_a.size(); k++) begin
            n_checks++; if (got_a[k] !== 32'h100 + 32'(4 * k)) $display("FAIL linear_addr[%0d] got %h want %h", k, got_a[k], 32'h100 + 32'(4 * k)); else n_pass++;
            n_checks++; if (got_d[k] !== mem_data(got_a[k])) $display("FAIL linear_data[%0d] got %h want %h", k, got_d[k], mem_data(got_a[k])); else n_pass++;
        end
        n_checks++; if (max_inflight > 2) $display("FAIL linear_outstanding got %0d want <=2", max_inflight); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] acc1[$]; logic [31:0] acc2[$];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, (i == 0), 32'h200, 1'b0, 1'b1, 1'b1, 1'b0);
            if (cyc_acc) acc1.push_back(obs_ta);
        end
        n_checks++; if (acc1.size() != 2) $display("FAIL bp_requests got %0d want 2", acc1.size()); else n_pass++;
        if (acc1.size() == 2) begin
            n_checks++; if (acc1[0] !== 32'h200 || acc1[1] !== 32'h204) $display("FAIL bp_addrs got %h,%h want 200,204", acc1[0], acc1[1]); else n_pass++;
        end
        n_checks++; if (obs_tv !== 1'b0) $display("FAIL bp_stalled_tvalid got %b want 0", obs_tv); else n_pass++;
        step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        if (cyc_acc) acc2.push_back(obs_ta);
        n_checks++; if (obs_head.addr !== 32'h200) $display("FAIL bp_pop_addr got %h want 200", obs_head.addr); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
            if (cyc_acc) acc2.push_back(obs_ta);
        end
        n_checks++; if (acc2.size() != 1) $display("FAIL bp_refill_count got %0d want 1", acc2.size()); else n_pass++;
        if (acc2.size() == 1) begin
            n_checks++; if (acc2[0] !== 32'h208) $display("FAIL bp_refill_addr got %h want 208", acc2[0]); else n_pass++;
        end
    endtask

    task automatic test_flush_inflight();
        logic [31:0] pa[$]; logic [31:0] pd[$];
        do_reset();
        step_a(1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (dut_inflight != 2) $display("FAIL flush_setup got %0d want 2 outstanding", dut_inflight); else n_pass++;
        step_a(1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (obs_tv !== 1'b0) $display("FAIL flush_no_credit got %b want 0", obs_tv); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
            n_checks++; if (obs_tv !== exp_tv || (exp_tv && obs_ta !== exp_ta)) $display("FAIL flush_req cyc %0d got %b/%h want %b/%h", i, obs_tv, obs_ta, exp_tv, exp_ta); else n_pass++;
            if (cyc_pop) begin pa.push_back(obs_head.addr); pd.push_back(obs_head.data); end
        end
        n_checks++; if (pa.size() < 2) $display("FAIL flush_pops got %0d want >=2", pa.size()); else n_pass++;
        if (pa.size() >= 2) begin
            n_checks++; if (pa[0] !== 32'h400 || pd[0] !== mem_data(32'h400)) $display("FAIL flush_first got %h/%h want 400/%h", pa[0], pd[0], mem_data(32'h400)); else n_pass++;
            n_checks++; if (pa[1] !== 32'h404) $display("FAIL flush_second got %h want 404", pa[1]); else n_pass++;
        end
    endtask

    task automatic test_err_wrap();
        logic [31:0] acc[$]; word_t pw[$];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step_a(1'b1, (i == 0), 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1'b1);
            if (cyc_acc) acc.push_back(obs_ta);
            if (cyc_pop) pw.push_back(obs_head);
        end
        n_checks++; if (acc.size() < 2) $display("FAIL wrap_reqs got %0d want >=2", acc.size()); else n_pass++;
        if (acc.size() >= 2) begin
            n_checks++; if (acc[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_first_req got %h want fffffffc", acc[0]); else n_pass++;
            n_checks++; if (acc[1] !== 32'h0000_0000) $display("FAIL wrap_next_req got %h want 00000000", acc[1]); else n_pass++;
        end
        n_checks++; if (pw.size() < 2) $display("FAIL wrap_pops got %0d want >=2", pw.size()); else n_pass++;
        if (pw.size() >= 2) begin
            n_checks++; if (pw[0].addr !== 32'hFFFF_FFFC || pw[0].err !== 1'b1) $display("FAIL err_head got %h/%b want fffffffc/1", pw[0].addr, pw[0].err); else n_pass++;
            n_checks++; if (pw[1].addr !== 32'h0 || pw[1].err !== 1'b0) $display("FAIL wrap_head got %h/%b want 00000000/0", pw[1].addr, pw[1].err); else n_pass++;
        end
    endtask

    task automatic test_kill();
        do_reset();
        step_a(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b1);
        step_a(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++; if (obs_tv !== 1'b0) $display("FAIL kill_tvalid got %b want 0", obs_tv); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
            n_checks++; if (obs_busy !== 1'b1 || obs_tv !== 1'b0) $display("FAIL kill_wait got busy %b tv %b want 1 0", obs_busy, obs_tv); else n_pass++;
        end
        step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (obs_busy !== 1'b1) $display("FAIL kill_busy_resp got %b want 1", obs_busy); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step_a(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
            n_checks++; if (obs_busy !== 1'b0 || obs_tv !== 1'b0 || obs_ov !== 1'b0) $display("FAIL kill_idle got busy %b tv %b ov %b want 0 0 0", obs_busy, obs_tv, obs_ov); else n_pass++;
        end
        step_a(1'b1, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (obs_tv !== 1'b1 || obs_ta !== 32'h600) $display("FAIL kill_restart got %b/%h want 1/600", obs_tv, obs_ta); else n_pass++;
    endtask

    task automatic test_random_model();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step_a(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), $urandom,
                   ($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));
            n_checks++; if (obs_tv !== exp_tv) $display("FAIL rnd_tvalid cyc %0d got %b want %b", i, obs_tv, exp_tv); else n_pass++;
            if (exp_tv) begin
                n_checks++; if (obs_ta !== exp_ta) $display("FAIL rnd_taddr cyc %0d got %h want %h", i, obs_ta, exp_ta); else n_pass++;
            end
            n_checks++; if (obs_ov !== exp_ov) $display("FAIL rnd_ovalid cyc %0d got %b want %b", i, obs_ov, exp_ov); else n_pass++;
            if (exp_ov) begin
                n_checks++; if (obs_head !== exp_head) $display("FAIL rnd_head cyc %0d got %h/%h/%b want %h/%h/%b", i, obs_head.addr, obs_head.data, obs_head.err, exp_head.addr, exp_head.data, exp_head.err); else n_pass++;
            end
            n_checks++; if (obs_busy !== exp_busy) $display("FAIL rnd_busy cyc %0d got %b want %b", i, obs_busy, exp_busy); else n_pass++;
        end
    endtask

    task automatic test_depth3_stream();
        logic [31:0] bus_q[$]; logic [31:0] expect_addr, tgt, ra;
        bit br, rsp, ordy, tr;
        int pops = 0, maxb = 0;
        expect_addr = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            br   = (i == 0) || ($urandom_range(0, 99) == 0);
            tgt  = $urandom & 32'hFFFF_FFFC;
            rsp  = (bus_q.size() > 0) && ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            tr   = ($urandom_range(0, 2) != 0);
            b_fetch_en = 1'b1; b_kill = 1'b0; b_branch = br;
            b_baddr = tgt | 32'($urandom_range(0, 3));
            b_tready = tr; b_ordy = ordy; b_rvalid = rsp;
            ra = rsp ? bus_q.pop_front() : 32'h0;
            b_rdata = rsp ? mem_data(ra) : $urandom;
            b_rerr  = rsp ? err_of(ra) : 1'b0;
            #2;
            if (b_ovalid && ordy && !br) begin
                n_checks++;
                if (b_oaddr !== expect_addr || b_ordata !== mem_data(expect_addr) || b_oerr !== err_of(expect_addr))
                    $display("FAIL d3_stream pop %0d got %h/%h/%b want %h/%h/%b", pops, b_oaddr, b_ordata, b_oerr, expect_addr, mem_data(expect_addr), err_of(expect_addr));
                else n_pass++;
                expect_addr = expect_addr + 32'd4;
                pops++;
            end
            if (b_tvalid && tr) bus_q.push_back(b_taddr);
            if (bus_q.size() > maxb) maxb = bus_q.size();
            if (br) expect_addr = tgt;
        end
        n_checks++; if (maxb > MB) $display("FAIL d3_outstanding got %0d want <=%0d", maxb, MB); else n_pass++;
        n_checks++; if (pops < 100) $display("FAIL d3_progress got %0d pops want >=100", pops); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_linear();
        test_backpressure();
        test_flush_inflight();
        test_err_wrap();
        test_kill();
        test_random_model();
        test_reset();
        test_depth3_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
